// File: rtl/xor_decipher_rx.sv
// Receive side of the XOR stream-cipher link: sync-word hunt, keystream
// regeneration, byte packing and a single-entry valid/ready output register.
//
// state | meaning
// HUNT  | shifting raw bits looking for SYNC_WORD; LFSR frozen
// DATA  | locked; decrypting and packing FRAME_BYTES payload bytes
module xor_decipher_rx #(
  parameter logic [31:0] TAPS        = 32'h0000_0060,
  parameter logic [31:0] SEED        = 32'h0000_0001,
  parameter logic [15:0] SYNC_WORD   = 16'hA5C3,
  parameter int unsigned FRAME_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       use_ext_key,
  input  logic       key_ext,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       locked,
  output logic       frame_done,
  output logic       overflow
);

  typedef enum logic {ST_HUNT, ST_DATA} state_e;

  localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);

  state_e      state_q, state_d;
  // Only the 15 most recent bits need storing; the 16th is the incoming bit.
  logic [14:0] sync_q, sync_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  // Partial byte: the 8th bit goes straight into m_data, so 7 bits suffice.
  logic [6:0]  byte_q, byte_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        frame_done_q, frame_done_d;
  logic        overflow_q, overflow_d;

  logic [15:0] sync_shift;
  logic        key_bit;
  logic        plain_bit;
  logic [7:0]  byte_full;
  logic [31:0] lfsr_next;

  assign sync_shift = {sync_q, bit_in};
  assign key_bit    = use_ext_key ? key_ext : lfsr_q[0];
  assign plain_bit  = bit_in ^ key_bit;
  assign byte_full  = {byte_q, plain_bit};
  assign lfsr_next  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);

  // Register all state; reset discards partial bytes and pending output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_HUNT;
      sync_q       <= '0;
      lfsr_q       <= SEED;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      byte_q       <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      lfsr_q       <= lfsr_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      byte_q       <= byte_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  // Next-state: sync hunt, decryption/packing, and output-register handshake.
  always_comb begin
    state_d      = state_q;
    sync_d       = sync_q;
    lfsr_d       = lfsr_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    byte_d       = byte_q;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;

    // A handshake frees the register; a byte completing this cycle refills it below.
    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      ST_HUNT: begin
        if (bit_valid) begin
          sync_d = sync_shift[14:0];
          if (sync_shift == SYNC_WORD) begin
            state_d    = ST_DATA;
            lfsr_d     = SEED;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            byte_d     = '0;
            overflow_d = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (bit_valid) begin
          byte_d    = byte_full[6:0];
          lfsr_d    = lfsr_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_cnt_d = byte_cnt_q + 8'd1;
            if (m_valid_q && !m_ready) begin
              overflow_d = 1'b1;
            end else begin
              m_data_d  = byte_full;
              m_valid_d = 1'b1;
            end
            if (byte_cnt_q == LAST_BYTE) begin
              frame_done_d = 1'b1;
              state_d      = ST_HUNT;
              sync_d       = '0;
              bit_cnt_d    = '0;
              byte_cnt_d   = '0;
            end
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign locked     = (state_q == ST_DATA);
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_xor_decipher_rx.sv
// Self-checking bench for xor_decipher_rx (FRAME_BYTES=2) with a keystream model.
module tb_xor_decipher_rx;
  localparam logic [31:0] TAPS = 32'h0000_0060;
  localparam logic [31:0] SEED = 32'h0000_0001;
  localparam logic [15:0] SYNC = 16'hA5C3;
  localparam int          FB   = 2;

  logic       clk, rst, bit_in, bit_valid, use_ext_key, key_ext, m_ready;
  logic [7:0] m_data;
  logic       m_valid, locked, frame_done, overflow;

  xor_decipher_rx #(.TAPS(TAPS), .SEED(SEED), .SYNC_WORD(SYNC), .FRAME_BYTES(FB)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .use_ext_key(use_ext_key), .key_ext(key_ext), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .locked(locked),
    .frame_done(frame_done), .overflow(overflow));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          fd_count = 0;
  logic [31:0] mdl_lfsr;
  logic [7:0]  rx_q[$];

  // Collect delivered bytes and frame_done pulses mid-cycle.
  always @(negedge clk) begin
    if (rst && m_valid && m_ready) rx_q.push_back(m_data);
    if (rst && frame_done) fd_count++;
  end

  task automatic put_bit(input logic b, input logic k, input logic ext);
    @(posedge clk); #1;
    bit_in = b; key_ext = k; use_ext_key = ext; bit_valid = 1'b1;
  endtask

  task automatic gap();
    @(posedge clk); #1;
    bit_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; use_ext_key = 1'b0; key_ext = 1'b0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap_pct);
    for (int i = 15; i >= 0; i--) begin
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) gap();
      put_bit(w[i], 1'b0, 1'b0);
    end
  endtask

  // Sends one ciphertext byte MSB first and predicts its plaintext.
  task automatic send_byte_m(input logic [7:0] ct, input logic ext, input logic [7:0] kx,
                             input int gap_pct, input logic rdy_last, output logic [7:0] pt);
    logic k;
    for (int i = 7; i >= 0; i--) begin
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) gap();
      put_bit(ct[i], kx[i], ext);
      k = ext ? kx[i] : mdl_lfsr[0];
      pt[i] = ct[i] ^ k;
      mdl_lfsr = (mdl_lfsr >> 1) ^ (mdl_lfsr[0] ? TAPS : 32'h0);
      if (i == 0 && rdy_last) m_ready = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; use_ext_key = 1'b0; key_ext = 1'b0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %h want 00", m_data); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst = 1'b1;
  endtask

  task automatic test_known_vector();
    logic [7:0] pt0, pt1;
    m_ready = 1'b1;
    send_word(SYNC, 0); gap();
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL kv_lock: got %b want 1", locked); end
    mdl_lfsr = SEED;
    send_byte_m(8'h83, 1'b0, 8'h00, 0, 1'b0, pt0); gap();
    n_checks++; if (m_valid !== 1'b1 || m_data !== 8'h00) begin n_fail++; $display("FAIL kv_byte0: got v=%b d=%h want v=1 d=00", m_valid, m_data); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL kv_fd_early: got %b want 0", frame_done); end
    send_byte_m(8'($urandom), 1'b0, 8'h00, 0, 1'b0, pt1); gap();
    n_checks++; if (m_valid !== 1'b1 || m_data !== pt1) begin n_fail++; $display("FAIL kv_byte1: got v=%b d=%h want v=1 d=%h", m_valid, m_data, pt1); end
    n_checks++; if (frame_done !== 1'b1 || locked !== 1'b0) begin n_fail++; $display("FAIL kv_frame_end: got fd=%b lk=%b want fd=1 lk=0", frame_done, locked); end
    gap();
    n_checks++; if (m_valid !== 1'b0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL kv_drain: got v=%b fd=%b want 0 0", m_valid, frame_done); end
  endtask

  task automatic test_reload();
    logic [7:0] pt0, pt1;
    send_word(SYNC, 0); mdl_lfsr = SEED;
    send_byte_m(8'h00, 1'b0, 8'h00, 0, 1'b0, pt0); gap();
    n_checks++; if (m_data !== 8'h83) begin n_fail++; $display("FAIL reload_byte0: got %h want 83", m_data); end
    send_byte_m(8'($urandom), 1'b0, 8'h00, 0, 1'b0, pt1); gap();
    n_checks++; if (m_data !== pt1) begin n_fail++; $display("FAIL reload_byte1: got %h want %h", m_data, pt1); end
    gap();
  endtask

  task automatic test_ext_key();
    logic [7:0] pt0, pt1;
    send_word(SYNC, 0); mdl_lfsr = SEED;
    send_byte_m(8'h5A, 1'b1, 8'h00, 0, 1'b0, pt0); gap();
    n_checks++; if (m_data !== 8'h5A) begin n_fail++; $display("FAIL ext_passthru: got %h want 5A", m_data); end
    send_byte_m(8'($urandom), 1'b0, 8'h00, 0, 1'b0, pt1); gap();
    n_checks++; if (m_data !== pt1) begin n_fail++; $display("FAIL ext_lfsr_advanced: got %h want %h", m_data, pt1); end
    gap();
  endtask

  task automatic test_overflow();
    logic [7:0] pt0, pt1;
    m_ready = 1'b0;
    send_word(SYNC, 0); mdl_lfsr = SEED;
    send_byte_m(8'($urandom), 1'b0, 8'h00, 20, 1'b0, pt0); gap();
    n_checks++; if (m_valid !== 1'b1 || m_data !== pt0 || overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_byte0: got v=%b d=%h o=%b want 1 %h 0", m_valid, m_data, overflow, pt0); end
    send_byte_m(8'($urandom), 1'b0, 8'h00, 20, 1'b0, pt1); gap();
    n_checks++; if (m_data !== pt0 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_hold: got d=%h o=%b want %h 1", m_data, overflow, pt0); end
    n_checks++; if (frame_done !== 1'b1 || m_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_fd: got fd=%b v=%b want 1 1", frame_done, m_valid); end
    m_ready = 1'b1; gap();
    n_checks++; if (m_valid !== 1'b0 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got v=%b o=%b want 0 1", m_valid, overflow); end
    send_word(SYNC, 0); gap();
    n_checks++; if (overflow !== 1'b0 || locked !== 1'b1) begin n_fail++; $display("FAIL ovf_clear_on_lock: got o=%b lk=%b want 0 1", overflow, locked); end
    do_reset();
  endtask

  task automatic test_late_ready();
    logic [7:0] pt0, pt1;
    m_ready = 1'b0;
    send_word(SYNC, 0); mdl_lfsr = SEED;
    send_byte_m(8'($urandom), 1'b0, 8'h00, 0, 1'b0, pt0);
    send_byte_m(8'($urandom), 1'b0, 8'h00, 0, 1'b1, pt1); gap();
    n_checks++; if (m_valid !== 1'b1 || m_data !== pt1 || overflow !== 1'b0) begin n_fail++; $display("FAIL late_rdy: got v=%b d=%h o=%b want 1 %h 0", m_valid, m_data, overflow, pt1); end
    gap();
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL late_rdy_drain: got %b want 0", m_valid); end
  endtask

  task automatic test_noise_sync();
    logic [3:0] noise;
    do_reset();
    noise = 4'b1101;
    for (int i = 3; i >= 0; i--) begin put_bit(noise[i], 1'b0, 1'b0); gap(); end
    for (int i = 15; i >= 1; i--) begin put_bit(SYNC[i], 1'b0, 1'b0); if (i % 2 == 0) gap(); end
    gap();
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL noise_early_lock: got %b want 0", locked); end
    put_bit(SYNC[0], 1'b0, 1'b0); gap();
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL noise_lock: got %b want 1", locked); end
    do_reset();
    send_word(16'hA5C2, 0); gap(); gap();
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL near_miss: got %b want 0", locked); end
    do_reset();
  endtask

  task automatic test_reset_mid();
    logic [7:0] pt0, pt1;
    m_ready = 1'b0;
    send_word(SYNC, 0); mdl_lfsr = SEED;
    send_byte_m(8'($urandom), 1'b0, 8'h00, 0, 1'b0, pt0); gap();
    for (int i = 0; i < 4; i++) put_bit(1'($urandom), 1'b0, 1'b0);
    #2 rst = 1'b0; bit_valid = 1'b0;
    #1;
    n_checks++; if (m_valid !== 1'b0 || m_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_out: got v=%b d=%h want 0 00", m_valid, m_data); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rstmid_locked: got %b want 0", locked); end
    @(posedge clk); #1 rst = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 12; i++) put_bit(1'b0, 1'b0, 1'b0);
    gap();
    n_checks++; if (locked !== 1'b0 || m_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_needs_sync: got lk=%b v=%b want 0 0", locked, m_valid); end
    send_word(SYNC, 0); mdl_lfsr = SEED;
    send_byte_m(8'($urandom), 1'b0, 8'h00, 0, 1'b0, pt0); gap();
    n_checks++; if (m_data !== pt0) begin n_fail++; $display("FAIL rstmid_resync: got %h want %h", m_data, pt0); end
    send_byte_m(8'($urandom), 1'b0, 8'h00, 0, 1'b0, pt1); gap(); gap();
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] pt;
    rx_q.delete(); fd_count = 0; m_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      send_word(SYNC, 30); mdl_lfsr = SEED;
      for (int b = 0; b < FB; b++) begin
        send_byte_m(8'($urandom), 1'($urandom), 8'($urandom), 30, 1'b0, pt);
        exp_q.push_back(pt);
      end
      gap(); gap();
    end
    gap();
    n_checks++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
    n_checks++; if (fd_count != 6) begin n_fail++; $display("FAIL rand_frames: got %0d want 6", fd_count); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_reload();
    test_ext_key();
    test_overflow();
    test_late_ready();
    test_noise_sync();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
